// File: rtl/seg16_pkg.sv
// Shared types and constants for the 16-segment scroll controller slice.
package seg16_pkg;

   typedef logic [7:0] char_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      WAIT
   } state_t;

   localparam int unsigned NUM_DIGITS_DEF = 6;
   localparam char_t       BLANK_CHAR_DEF = 8'h20;
   localparam char_t       ASCII_LOWER_A  = 8'h61;
   localparam char_t       ASCII_LOWER_Z  = 8'h7A;

   // Lower-case ASCII letters map to upper case; everything else passes through.
   function automatic char_t to_upper(input char_t c);
      if ((c >= ASCII_LOWER_A) && (c <= ASCII_LOWER_Z)) begin
         return c - 8'h20;
      end
      return c;
   endfunction

endpackage

// File: rtl/seg16_msg_buf.sv
// Message character storage: one synchronous write port, one combinational
// read port. Carries no length or sequencing logic.
module seg16_msg_buf
   import seg16_pkg::*;
#(
   parameter int unsigned MAX_MSG = 32,
   localparam int unsigned IW     = (MAX_MSG > 1) ? $clog2(MAX_MSG) : 1
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [IW-1:0] wr_idx_i,
   input  char_t         wr_data_i,
   input  logic [IW-1:0] rd_idx_i,
   output char_t         rd_data_o
);

   char_t mem_q [MAX_MSG];

   // Store an accepted character at its message index.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/seg16_scroll_ctrl.sv
// Sequencer feeding the 6-digit 16-segment display driver: collects an ASCII
// message, writes a NUM_DIGITS-wide window into the driver's character store
// (one position per matching digit_sel) and scrolls long messages.
// Optional build macro SEG16_UPPERCASE_EN: store 'a'..'z' as upper case.
module seg16_scroll_ctrl
   import seg16_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
   parameter int unsigned MAX_MSG    = 32,
   parameter int unsigned SCROLL_DIV = 25000000,
   parameter char_t       BLANK_CHAR = BLANK_CHAR_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       msg_valid,
   output logic       msg_ready,
   input  logic [7:0] msg_char,
   input  logic       msg_last,
   input  logic       msg_clear,
   input  logic       scroll_en,
   input  logic [2:0] disp_digit_sel,
   output logic       disp_load,
   output logic [7:0] disp_char,
   output logic       busy,
   output logic [5:0] msg_len
);

   localparam int unsigned LW = $clog2(MAX_MSG + 1);
   localparam int unsigned OW = (MAX_MSG > 1) ? $clog2(MAX_MSG) : 1;
   localparam int unsigned TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

   state_t        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [OW-1:0] offset_q, offset_d;
   logic [2:0]    wr_pos_q, wr_pos_d;
   logic [TW-1:0] timer_q, timer_d;

   logic          buf_we;
   logic [OW-1:0] buf_wr_idx;
   char_t         in_char;
   logic [OW-1:0] rd_idx;
   char_t         rd_char;
   logic [LW:0]   win_sum;
   logic          scroll_mode;
   logic          digit_hit;
   char_t         win_char;

`ifdef SEG16_UPPERCASE_EN
   assign in_char = to_upper(msg_char);
`else
   assign in_char = msg_char;
`endif

   assign scroll_mode = (len_q > LW'(NUM_DIGITS));
   assign digit_hit   = (disp_digit_sel == wr_pos_q);

   seg16_msg_buf #(
      .MAX_MSG (MAX_MSG)
   ) u_msg_buf (
      .clk       (clk),
      .we_i      (buf_we),
      .wr_idx_i  (buf_wr_idx),
      .wr_data_i (in_char),
      .rd_idx_i  (rd_idx),
      .rd_data_o (rd_char)
   );

   // Window lookup: (offset + wr_pos) mod len via a single conditional subtract.
   always_comb begin
      win_sum = (LW+1)'(offset_q) + (LW+1)'(wr_pos_q);
      if (win_sum >= {1'b0, len_q}) begin
         win_sum = win_sum - {1'b0, len_q};
      end
      rd_idx   = scroll_mode ? OW'(win_sum) : OW'(wr_pos_q);
      win_char = (scroll_mode || (LW'(wr_pos_q) < len_q)) ? rd_char : BLANK_CHAR;
   end

   // State register and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         len_q    <= '0;
         offset_q <= '0;
         wr_pos_q <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         offset_q <= offset_d;
         wr_pos_q <= wr_pos_d;
         timer_q  <= timer_d;
      end
   end

   // Next-state logic; msg_clear overrides every state and any valid character.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      offset_d   = offset_q;
      wr_pos_d   = wr_pos_q;
      timer_d    = timer_q;
      buf_we     = 1'b0;
      buf_wr_idx = OW'(len_q);
      if (msg_clear) begin
         // Empty message makes every window position blank; WRITE then exits to IDLE.
         state_d  = WRITE;
         len_d    = '0;
         offset_d = '0;
         wr_pos_d = '0;
         timer_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (msg_valid) begin
                  buf_we     = 1'b1;
                  buf_wr_idx = '0;
                  len_d      = LW'(1);
                  offset_d   = '0;
                  wr_pos_d   = '0;
                  timer_d    = '0;
                  state_d    = (msg_last || (MAX_MSG == 1)) ? WRITE : LOAD;
               end
            end
            LOAD: begin
               if (msg_valid) begin
                  buf_we = 1'b1;
                  len_d  = len_q + 1'b1;
                  if (msg_last || (len_q == LW'(MAX_MSG - 1))) begin
                     state_d = WRITE;
                  end
               end
            end
            WRITE: begin
               if (digit_hit) begin
                  if (wr_pos_q == 3'(NUM_DIGITS - 1)) begin
                     wr_pos_d = '0;
                     timer_d  = '0;
                     state_d  = (len_q == '0) ? IDLE : WAIT;
                  end else begin
                     wr_pos_d = wr_pos_q + 3'd1;
                  end
               end
            end
            WAIT: begin
               if (scroll_mode && scroll_en) begin
                  if (timer_q == TW'(SCROLL_DIV - 1)) begin
                     timer_d  = '0;
                     offset_d = (LW'(offset_q) == (len_q - 1'b1)) ? '0 : offset_q + 1'b1;
                     state_d  = WRITE;
                  end else begin
                     timer_d = timer_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs decoded from registered state plus msg_clear / digit_sel.
   always_comb begin
      msg_ready = 1'b0;
      disp_load = 1'b0;
      disp_char = BLANK_CHAR;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            msg_ready = !msg_clear;
            busy      = 1'b0;
         end
         LOAD: msg_ready = !msg_clear;
         WRITE: begin
            disp_load = digit_hit && !msg_clear;
            disp_char = win_char;
         end
         default: ;
      endcase
   end

   assign msg_len = 6'(len_q);

endmodule

// File: tb/tb_seg16_scroll_ctrl.sv
// Self-checking bench for seg16_scroll_ctrl with a behavioural window model.
`timescale 1ns/1ps
module tb_seg16_scroll_ctrl;

   localparam int ND = 6;
   localparam int MM = 32;
   localparam int SD = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       msg_valid = 1'b0;
   logic [7:0] msg_char = 8'h00;
   logic       msg_last = 1'b0;
   logic       msg_clear = 1'b0;
   logic       scroll_en = 1'b1;
   logic [2:0] disp_digit_sel = 3'd0;
   logic       msg_ready;
   logic       disp_load;
   logic [7:0] disp_char;
   logic       busy;
   logic [5:0] msg_len;

   seg16_scroll_ctrl #(
      .NUM_DIGITS (ND),
      .MAX_MSG    (MM),
      .SCROLL_DIV (SD),
      .BLANK_CHAR (8'h20)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .msg_valid      (msg_valid),
      .msg_ready      (msg_ready),
      .msg_char       (msg_char),
      .msg_last       (msg_last),
      .msg_clear      (msg_clear),
      .scroll_en      (scroll_en),
      .disp_digit_sel (disp_digit_sel),
      .disp_load      (disp_load),
      .disp_char      (disp_char),
      .busy           (busy),
      .msg_len        (msg_len)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         sel;
      logic [7:0] ch;
      int         cyc;
   } load_t;

   load_t      lq[$];
   logic [7:0] mem[$];
   logic [7:0] tx[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sel_at(input int c);
      return (c / 4) % ND;
   endfunction

   function automatic int next_sel0(input int c);
      int x = c;
      while (sel_at(x) != 0) x++;
      return x;
   endfunction

   function automatic logic [7:0] exp_store(input logic [7:0] c);
`ifdef SEG16_UPPERCASE_EN
      if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
      return c;
   endfunction

   function automatic logic [7:0] win_char(input int p, input int off);
      int n = mem.size();
      if (n > ND) return mem[(off + p) % n];
      if (p < n) return mem[p];
      return 8'h20;
   endfunction

   // Display driver model: digit_sel steps 0..5, one step every 4 cycles.
   initial forever begin
      @(posedge clk);
      cyc++;
      #2;
      disp_digit_sel = 3'(sel_at(cyc));
   end

   // Record every display write strobe.
   always @(negedge clk) begin
      load_t e;
      if (disp_load === 1'b1) begin
         e.sel = int'(disp_digit_sel);
         e.ch  = disp_char;
         e.cyc = cyc;
         lq.push_back(e);
      end
   end

   task automatic load_str(input string s);
      tx.delete();
      for (int i = 0; i < s.len(); i++) tx.push_back(s[i]);
   endtask

   task automatic send(input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         msg_valid = 1'b1;
         msg_char  = tx[i];
         msg_last  = with_last && (i == n - 1);
         @(negedge clk);
         check("msg_ready_accept", msg_ready, 1);
         mem.push_back(exp_store(tx[i]));
      end
      @(posedge clk); #1;
      msg_valid = 1'b0;
      msg_last  = 1'b0;
   endtask

   task automatic wait_loads(input int n, input int budget);
      int k = 0;
      while (lq.size() < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check("load_count", lq.size(), n);
   endtask

   task automatic check_window(input int base, input int off);
      if (lq.size() < base + ND) return;
      for (int p = 0; p < ND; p++) begin
         check("win_sel", lq[base + p].sel, p);
         check("win_char", lq[base + p].ch, win_char(p, off));
      end
   endtask

   task automatic do_clear(input bit at_sel3, input bit with_valid);
      int k = 0;
      @(posedge clk); #1;
      while (at_sel3 && sel_at(cyc) != 3 && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      msg_clear = 1'b1;
      msg_valid = with_valid;
      msg_char  = 8'h5A;
      msg_last  = 1'b1;
      @(negedge clk);
      check("clear_disp_load", disp_load, 0);
      check("clear_msg_ready", msg_ready, 0);
      @(posedge clk); #1;
      msg_clear = 1'b0;
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      lq.delete();
      mem.delete();
      wait_loads(ND, 80);
      check_window(0, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_ready", msg_ready, 1);
      check("idle_len", msg_len, 0);
      lq.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int n;
      // Reset values while rst is held.
      #12;
      check("rst_ready", msg_ready, 1);
      check("rst_load", disp_load, 0);
      check("rst_char", disp_char, 8'h20);
      check("rst_busy", busy, 0);
      check("rst_len", msg_len, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Short static message.
      load_str("HELLO");
      send(5, 1);
      wait_loads(ND, 120);
      check_window(0, 0);
      repeat (60) @(negedge clk);
      #1;
      check("static_no_more_loads", lq.size(), ND);
      check("static_len", msg_len, 5);
      check("static_busy", busy, 1);
      check("static_ready", msg_ready, 0);
      do_clear(0, 0);

      // Lower-case handling.
      load_str("hi");
      send(2, 1);
      wait_loads(ND, 120);
      check_window(0, 0);
      do_clear(0, 0);

      // Scrolling message, full offset wrap.
      load_str("ABCDEFGH");
      scroll_en = 1'b1;
      send(8, 1);
      for (int k = 0; k <= 8; k++) begin
         wait_loads(ND * (k + 1), 150);
         check_window(ND * k, k % 8);
         if (k > 0 && lq.size() >= ND * (k + 1))
            check("scroll_gap", lq[ND * k].cyc, next_sel0(lq[ND * k - 1].cyc + SD + 1));
      end
      check("scroll_len", msg_len, 8);

      // Freeze the timer for 40 cycles inside WAIT.
      t = (lq.size() >= 54) ? lq[53].cyc : cyc;
      @(posedge clk); @(posedge clk); #1;
      scroll_en = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("pause_no_loads", lq.size(), 54);
      scroll_en = 1'b1;
      wait_loads(60, 150);
      check_window(54, 1);
      if (lq.size() >= 60) check("pause_gap", lq[54].cyc, next_sel0(t + SD + 1 + 40));

      // Clear at wr_pos=3 while a character is offered.
      wait_loads(63, 150);
      do_clear(1, 1);

      // Buffer-full: 33 characters, no last.
      tx.delete();
      for (int i = 0; i < 33; i++) tx.push_back(8'($urandom_range(33, 126)));
      send(32, 0);
      @(posedge clk); #1;
      msg_valid = 1'b1;
      msg_char  = tx[32];
      @(negedge clk);
      check("full_ready", msg_ready, 0);
      check("full_len", msg_len, 32);
      @(posedge clk); #1;
      msg_valid = 1'b0;
      wait_loads(ND, 120);
      check_window(0, 0);
      do_clear(0, 0);

      // Random messages, first window and (when long) first scroll step.
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 12);
         tx.delete();
         for (int i = 0; i < n; i++) tx.push_back(8'($urandom_range(32, 126)));
         send(n, 1);
         check("rand_len", msg_len, n);
         wait_loads(ND, 120);
         check_window(0, 0);
         if (n > ND) begin
            wait_loads(2 * ND, 150);
            check_window(ND, 1);
            if (lq.size() >= 2 * ND)
               check("rand_gap", lq[ND].cyc, next_sel0(lq[ND - 1].cyc + SD + 1));
         end
         do_clear(0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
